// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART 8N1 receiver feeding a first-word-fall-through FIFO with a
//   valid/ready drain port. Framing and overflow problems raise sticky flags.
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   asynchronous, active-low reset
//   rxd        in   serial line, idle high, asynchronous to clk
//   out_data   out  byte at the FIFO head (undefined while out_valid=0)
//   out_valid  out  FIFO not empty
//   out_ready  in   consumer takes the head byte when out_valid is high
//   count      out  FIFO occupancy, 0..DEPTH
//   frame_err  out  sticky: a stop bit was sampled low
//   overrun    out  sticky: a received byte was dropped on a full FIFO
//   err_clr    in   clears both sticky flags; wins over a same-cycle set
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 5,
    parameter int DEPTH        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rxd,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     frame_err,
    output logic                     overrun,
    input  logic                     err_clr
);

    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int AW   = $clog2(DEPTH);
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CW-1:0] HALF_C  = CW'(HALF);
    localparam logic [CW-1:0] LAST_C  = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Synchronizer
    logic sync1, rxs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    // Receive FSM
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    idx, idx_nx;
    logic [7:0]    shreg, shreg_nx;
    logic          push;
    logic          frame_set;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            shreg <= shreg_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        idx_nx    = idx;
        shreg_nx  = shreg;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state)
            IDLE: begin
                if (!rxs) begin
                    cnt_nx   = '0;
                    state_nx = START;
                end
            end
            START: begin
                if (cnt == HALF_C) begin
                    if (!rxs) begin
                        cnt_nx   = '0;
                        idx_nx   = '0;
                        state_nx = DATA;
                    end else begin
                        // Start bit gone by mid-bit: treat as a glitch.
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            DATA: begin
                if (cnt == LAST_C) begin
                    shreg_nx = {rxs, shreg[7:1]};
                    cnt_nx   = '0;
                    if (idx == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        idx_nx = idx + 3'd1;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets a back-to-back start edge be seen.
                if (cnt == LAST_C) begin
                    state_nx = IDLE;
                    if (rxs) begin
                        push = 1'b1;
                    end else begin
                        frame_set = 1'b1;
                    end
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FIFO
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pop, push_ok, drop;

    assign pop       = out_valid && out_ready;
    // A same-cycle pop frees the slot, so a full FIFO can still accept.
    assign push_ok   = push && ((count < DEPTH_C) || pop);
    assign drop      = push && !push_ok;
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (err_clr) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (frame_set) begin
                frame_err <= 1'b1;
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Self-checking bench for uart_rx_fifo at 5 clocks per bit, 16-deep FIFO.
//   Bytes expected to reach the consumer are queued when their frame is
//   driven and compared when the DUT hands them out.
module tb_uart_rx_fifo;

    localparam int C     = 5;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;

    uart_rx_fifo #(
        .CLKS_PER_BIT(C),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .rxd(rxd),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count(count),
        .frame_err(frame_err),
        .overrun(overrun),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int         n_cmp  = 0;
    int         n_err  = 0;
    int         n_pops = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Handshake completes at the next rising edge; compare the head now.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_pops++;
            check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame. With pulse_ready, out_ready is high only for the
    // edge where the stop bit is sampled (6 edges after the stop bit starts).
    task automatic send(input logic [7:0] b, input logic stop_bit, input logic keep,
                        input logic pulse_ready, input int gap_bits);
        if (keep) exp_q.push_back(b);
        tick();
        rxd = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (C) tick();
        end
        rxd = stop_bit;
        for (int k = 1; k <= (pulse_ready ? C + 1 : C); k++) begin
            tick();
            if (k == C) begin
                rxd = 1'b1;
                if (pulse_ready) out_ready = 1'b1;
            end
            if (k == C + 1) out_ready = 1'b0;
        end
        repeat (gap_bits * C) tick();
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 3000) begin
            tick();
            k++;
        end
        check({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops0;
        rst_n     = 1'b0;
        rxd       = 1'b1;
        out_ready = 1'b0;
        err_clr   = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Two frames, consumer always ready
        out_ready = 1'b1;
        pops0 = n_pops;
        send(8'h55, 1'b1, 1'b1, 1'b0, 0);
        send(8'hA3, 1'b1, 1'b1, 1'b0, 2);
        wait_drain("basic");
        check("basic_pops", 32'(n_pops - pops0), 32'd2);
        check("basic_ferr", 32'(frame_err), 32'd0);
        check("basic_ovr", 32'(overrun), 32'd0);

        // Overflow: 17 bytes into a 16-deep FIFO, last one lost
        out_ready = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            send(8'(i), 1'b1, (i < 16), 1'b0, 1);
        end
        check("full_count", 32'(count), 32'd16);
        check("full_ovr", 32'(overrun), 32'd1);
        out_ready = 1'b1;
        wait_drain("full_drain");
        check("drain_count", 32'(count), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);
        pulse_clr();
        check("ovr_clr", 32'(overrun), 32'd0);

        // One-clock glitch while idle
        out_ready = 1'b0;
        tick();
        rxd = 1'b0;
        tick();
        rxd = 1'b1;
        repeat (20) tick();
        check("glitch_count", 32'(count), 32'd0);
        check("glitch_valid", 32'(out_valid), 32'd0);

        // Bad stop bit, then a good frame
        send(8'h7E, 1'b0, 1'b0, 1'b0, 2);
        check("ferr_set", 32'(frame_err), 32'd1);
        check("ferr_count", 32'(count), 32'd0);
        pulse_clr();
        check("ferr_clr", 32'(frame_err), 32'd0);
        out_ready = 1'b1;
        send(8'h7E, 1'b1, 1'b1, 1'b0, 2);
        wait_drain("after_ferr");
        check("after_ferr_flag", 32'(frame_err), 32'd0);

        // Full FIFO, pop coinciding with the 17th byte's push
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(8'(8'h20 + i), 1'b1, 1'b1, 1'b0, 1);
        end
        check("full2_count", 32'(count), 32'd16);
        send(8'hC4, 1'b1, 1'b1, 1'b1, 1);
        check("simul_count", 32'(count), 32'd16);
        check("simul_ovr", 32'(overrun), 32'd0);
        out_ready = 1'b1;
        wait_drain("simul_drain");

        // Reset mid-frame: leave frame_err set first so reset must clear it
        send(8'h11, 1'b0, 1'b0, 1'b0, 2);
        check("pre_rst_ferr", 32'(frame_err), 32'd1);
        out_ready = 1'b0;
        tick();
        rxd = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1;
            repeat (C) tick();
        end
        rxd = 1'b0;
        tick();
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4 * C) tick();
        check("abort_count", 32'(count), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ferr", 32'(frame_err), 32'd0);
        out_ready = 1'b1;
        send(8'h3C, 1'b1, 1'b1, 1'b0, 2);
        wait_drain("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
